program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Upstream feeder for the CPU load port. It receives a framed byte stream over a valid/ready handshake and converts each entry into a one-cycle load pulse on the CPU's cpu_input, load_address, load and is_instruction inputs. It holds the CPU in reset while loading. Once the frame checksum is verified, it releases the CPU.

Parameters:
DATA_W, 8, width of data bytes and cpu_input
ADDR_W, 5, width of load_address; maximum entries per frame is 2**ADDR_W
START_BYTE, 8'hA5, frame start marker
TIMEOUT, 1000, maximum idle cycles allowed between bytes inside a frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_W  stream byte
in_valid  in  1  in_data is valid
in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid&&in_ready at a rising edge
cpu_input  out  DATA_W  value presented to the CPU
load_address  out  ADDR_W  target address
load  out  1  one-cycle write strobe
is_instruction  out  1  1 = instruction memory, 0 = data memory
cpu_reset_n  out  1  CPU reset; 0 holds the CPU in reset
busy  out  1  frame in progress
error  out  1  sticky frame error
done  out  1  last frame completed OK

Behaviour:
- Async reset (reset=0): state IDLE; all outputs 0, including cpu_reset_n=0 (CPU held).
- Frame format: START_BYTE, COUNT, then COUNT pairs of {CTRL, DATA}, then CHK.
  - CTRL[7] = is_instruction; CTRL[ADDR_W-1:0] = address; other CTRL bits are ignored.
  - CHK = XOR of COUNT and every CTRL and DATA byte.
- States: IDLE, COUNT, CTRL, DATA, LOAD, CHECK, RUN, ERR.
- IDLE: in_ready=1. Bytes other than START_BYTE are dropped. START_BYTE -> COUNT; clear error and done; set busy=1; cpu_reset_n=0.
- COUNT: if byte is 0 or greater than 2**ADDR_W -> ERR. Otherwise latch it into the remaining-entries counter, seed the checksum with it, and go to CTRL.
- CTRL: latch address and type; XOR into checksum -> DATA.
- DATA: latch byte; XOR into checksum -> LOAD.
- LOAD: lasts exactly one cycle, with in_ready=0.
  - load=1 while cpu_input, load_address and is_instruction hold the latched values.
  - Decrement the counter. If the counter is now 0 -> CHECK, else -> CTRL.
- Latency: a DATA byte accepted at edge N produces load=1 during the cycle after edge N.
- Address/data outputs keep their last values after the load pulse.
- Addresses are not required to be unique or ordered; the last write wins.
- CHECK: if the byte equals the checksum -> RUN, else -> ERR.
- RUN: cpu_reset_n=1, done=1, busy=0, in_ready=1.
  - START_BYTE received in RUN -> COUNT, with cpu_reset_n=0 on the next cycle (reload).
  - Other bytes in RUN are dropped.
- ERR: error=1, busy=0, cpu_reset_n=0. Behaves like IDLE: in_ready=1 and it waits for START_BYTE. error stays 1 until the next START_BYTE.
- Entries loaded before an error are not rolled back; the CPU stays in reset.
- Timeout: in COUNT, CTRL, DATA or CHECK, if no byte is accepted for TIMEOUT consecutive cycles -> ERR.
  - The timeout counter resets on every accepted byte and on entry to the state.
- in_valid held low is legal anywhere; states wait. in_data is sampled only on a transfer.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is discarded.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W/ADDR_W constants
  - START_BYTE
  - state enum loader_state_t
  - CTRL field positions (CTRL_TYPE_BIT=7)
- One sub-module: loader_timeout, a loadable down-counter with inputs clear and enable and a single-cycle expired output.
- All other logic stays in program_loader.

Test Plan:
- Reset and idle: hold reset=0, then release. Expect cpu_reset_n=0, load=0, in_ready=1. Then send 0x33, which must be dropped with no state change (busy=0).
- Valid frame: send A5,02,80,01,01,0F,8D.
  - Expect two load pulses: first (addr 0, instr=1, data 01), then (addr 1, instr=0, data 0F).
  - Each pulse is exactly one cycle, one cycle after its DATA byte.
  - Afterwards: done=1, cpu_reset_n=1, error=0.
- Bad checksum: send A5,01,82,02,02,00.
  - Expect one load (addr 2, instr=1, data 02), then error=1 with cpu_reset_n=0.
  - A following valid frame clears error and ends with done=1.
- Bad count and timeout:
  - A5,00 -> error=1 with no load.
  - A5,21 (33 > 32) -> error=1.
  - A5,01 then in_valid=0 for 1000 cycles -> error=1 exactly at the timeout.
- Backpressure and gaps: randomise in_valid gaps within the valid frame. Expect identical load pulses, and in_ready=0 during each LOAD cycle.
- Reload and mid-frame reset:
  - While in RUN, send A5 -> cpu_reset_n drops to 0 on the next cycle.
  - Assert reset during DATA -> outputs return to reset values immediately and no load pulse is issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU program loader.
// Holds the stream framing constants, CTRL byte layout and loader state encoding.
package cpu_pkg;

    localparam int         CPU_DATA_W     = 8;
    localparam int         CPU_ADDR_W     = 5;
    localparam logic [7:0] CPU_START_BYTE = 8'hA5;

    // CTRL byte layout: bit 7 selects instruction memory, low bits carry the address
    localparam int CTRL_TYPE_BIT = 7;
    localparam int CTRL_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_CTRL,
        S_DATA,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// flags expired for the single cycle in which the budget runs out.
module loader_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= LOAD_VAL;
        end else if (clear) begin
            count_q <= LOAD_VAL;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // The counter reads zero during the TIMEOUT-th consecutive idle cycle
    assign expired = enable && !clear && (count_q == '0);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU load port: turns each {CTRL, DATA} entry
// into a one-cycle load strobe and releases the CPU once the frame checksum matches.
module program_loader
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = CPU_DATA_W,
    parameter int                ADDR_W     = CPU_ADDR_W,
    parameter logic [DATA_W-1:0] START_BYTE = DATA_W'(CPU_START_BYTE),
    parameter int                TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] cpu_input,
    output logic [ADDR_W-1:0] load_address,
    output logic              load,
    output logic              is_instruction,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              error,
    output logic              done
);

    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [31:0] MAX_COUNT = 32'(1) << ADDR_W;

    loader_state_t     state_q, state_d;
    logic              xfer;
    logic              timed;
    logic              expired;
    logic              count_bad;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] chk_q;
    logic [ADDR_W-1:0] addr_q;
    logic              type_q;

    // Gating with reset keeps every output low while reset is held
    assign in_ready  = reset && (state_q != S_LOAD);
    assign xfer      = in_valid && in_ready;
    assign timed     = state_q inside {S_COUNT, S_CTRL, S_DATA, S_CHECK};
    assign count_bad = (in_data == '0) || (32'(in_data) > MAX_COUNT);

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!timed || xfer),
        .enable (timed && !xfer),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (xfer && (in_data == START_BYTE)) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (expired)   state_d = S_ERR;
                else if (xfer) state_d = count_bad ? S_ERR : S_CTRL;
            end
            S_CTRL: begin
                if (expired)   state_d = S_ERR;
                else if (xfer) state_d = S_DATA;
            end
            S_DATA: begin
                if (expired)   state_d = S_ERR;
                else if (xfer) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = (cnt_q == CNT_W'(1)) ? S_CHECK : S_CTRL;
            end
            S_CHECK: begin
                if (expired)   state_d = S_ERR;
                else if (xfer) state_d = (in_data == chk_q) ? S_RUN : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they track the FSM glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            load           <= 1'b0;
            cpu_input      <= '0;
            load_address   <= '0;
            is_instruction <= 1'b0;
            cpu_reset_n    <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q     <= state_d;
            load        <= (state_d == S_LOAD);
            cpu_reset_n <= (state_d == S_RUN);
            done        <= (state_d == S_RUN);
            error       <= (state_d == S_ERR);
            busy        <= state_d inside {S_COUNT, S_CTRL, S_DATA, S_LOAD, S_CHECK};

            if ((state_q == S_COUNT) && xfer) begin
                cnt_q <= in_data[CNT_W-1:0];
            end else if (state_q == S_LOAD) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // Address, type and data reach the CPU together, right as the strobe rises
            if ((state_q == S_DATA) && xfer) begin
                cpu_input      <= in_data;
                load_address   <= addr_q;
                is_instruction <= type_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            case (state_q)
                S_COUNT: chk_q <= in_data;
                S_CTRL: begin
                    chk_q  <= chk_q ^ in_data;
                    addr_q <= in_data[CTRL_ADDR_LSB +: ADDR_W];
                    type_q <= in_data[CTRL_TYPE_BIT];
                end
                S_DATA:  chk_q <= chk_q ^ in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a table of directed frames, hand-written corner sequences
// (reset, reload, timeout, mid-frame reset) and randomized streams against a frame parser model.
module tb_program_loader;

    localparam int TIMEOUT = 1000;
    localparam int ST_IDLE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_DONE = 2;
    localparam int ST_ERR  = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] cpu_input;
    logic [4:0] load_address;
    logic       load;
    logic       is_instruction;
    logic       cpu_reset_n;
    logic       busy;
    logic       error;
    logic       done;

    program_loader #(
        .DATA_W    (8),
        .ADDR_W    (5),
        .START_BYTE(8'hA5),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cpu_input     (cpu_input),
        .load_address  (load_address),
        .load          (load),
        .is_instruction(is_instruction),
        .cpu_reset_n   (cpu_reset_n),
        .busy          (busy),
        .error         (error),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int instr; int data; int cyc; } load_t;
    typedef struct { int addr; int instr; int data; int idx; } exp_t;
    typedef logic [7:0] bq_t[$];

    typedef struct {
        string      name;
        int         n;
        logic [7:0] bytes [8];
        int         nloads;
        int         a0, i0, d0, a1, i1, d1;
        int         e_error, e_done, e_busy, e_rstn;
    } vec_t;

    load_t obs[$];
    exp_t  exp_q[$];
    int    acc[$];
    vec_t  vecs[7];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Every load pulse is logged with the cycle it appeared in
    always @(negedge clk) begin
        if (reset && load) begin
            obs.push_back('{int'(load_address), int'(is_instruction), int'(cpu_input), cyc});
            check("ready_low_in_load", int'(in_ready), 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_wait", int'(in_ready), 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc.push_back(cyc);
            in_valid = 1'b0;
        end
    endtask

    // Reference: walk the byte stream as a frame parser and list the loads it implies
    task automatic run_model(input bq_t s, output int status);
        int p, cnt, k;
        logic [7:0] sum, c, d;
        p      = 0;
        status = ST_IDLE;
        exp_q.delete();
        while (p < s.size()) begin
            if (s[p] != 8'hA5) begin
                p++;
                continue;
            end
            p++;
            status = ST_BUSY;
            if (p >= s.size()) break;
            cnt = int'(s[p]);
            p++;
            if (cnt == 0 || cnt > 32) begin
                status = ST_ERR;
                continue;
            end
            sum = 8'(cnt);
            for (k = 0; k < cnt && p + 1 < s.size(); k++) begin
                c = s[p];
                d = s[p + 1];
                exp_q.push_back('{int'(c[4:0]), int'(c[7]), int'(d), p + 1});
                sum = sum ^ c ^ d;
                p += 2;
            end
            if (k < cnt || p >= s.size()) break;
            status = (s[p] == sum) ? ST_DONE : ST_ERR;
            p++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_obs, base_acc, c0, first, nobs;

        vecs[0] = '{"junk", 1, '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{"valid", 7, '{8'hA5, 8'h02, 8'h80, 8'h01, 8'h01, 8'h0F, 8'h8D, 8'h00},
                    2, 0, 1, 1, 1, 0, 15, 0, 1, 0, 1};
        vecs[2] = '{"badchk", 6, '{8'hA5, 8'h01, 8'h82, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00},
                    1, 2, 1, 2, 0, 0, 0, 1, 0, 0, 0};
        vecs[3] = '{"revalid", 7, '{8'hA5, 8'h02, 8'h80, 8'h01, 8'h01, 8'h0F, 8'h8D, 8'h00},
                    2, 0, 1, 1, 1, 0, 15, 0, 1, 0, 1};
        vecs[4] = '{"count0", 2, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{"count33", 2, '{8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[6] = '{"sameaddr", 7, '{8'hA5, 8'h02, 8'h63, 8'h11, 8'h63, 8'h22, 8'h31, 8'h00},
                    2, 3, 0, 17, 3, 0, 34, 0, 1, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_load", int'(load), 0);
        check("rst_cpu_reset_n", int'(cpu_reset_n), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cpu_input", int'(cpu_input), 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_cpu_reset_n", int'(cpu_reset_n), 0);

        for (int r = 0; r < 7; r++) begin
            base_obs = obs.size();
            base_acc = acc.size();
            for (int k = 0; k < vecs[r].n; k++) send_byte(vecs[r].bytes[k], 0);
            repeat (3) @(negedge clk);
            check({vecs[r].name, "_loads"}, obs.size() - base_obs, vecs[r].nloads);
            if (vecs[r].nloads > 0 && obs.size() > base_obs) begin
                check({vecs[r].name, "_addr0"}, obs[base_obs].addr, vecs[r].a0);
                check({vecs[r].name, "_instr0"}, obs[base_obs].instr, vecs[r].i0);
                check({vecs[r].name, "_data0"}, obs[base_obs].data, vecs[r].d0);
                check({vecs[r].name, "_lat0"}, obs[base_obs].cyc, acc[base_acc + 3]);
            end
            if (vecs[r].nloads > 1 && obs.size() > base_obs + 1) begin
                check({vecs[r].name, "_addr1"}, obs[base_obs + 1].addr, vecs[r].a1);
                check({vecs[r].name, "_instr1"}, obs[base_obs + 1].instr, vecs[r].i1);
                check({vecs[r].name, "_data1"}, obs[base_obs + 1].data, vecs[r].d1);
                check({vecs[r].name, "_lat1"}, obs[base_obs + 1].cyc, acc[base_acc + 5]);
            end
            check({vecs[r].name, "_error"}, int'(error), vecs[r].e_error);
            check({vecs[r].name, "_done"}, int'(done), vecs[r].e_done);
            check({vecs[r].name, "_busy"}, int'(busy), vecs[r].e_busy);
            check({vecs[r].name, "_cpu_reset_n"}, int'(cpu_reset_n), vecs[r].e_rstn);
        end

        // Reload from RUN: the CPU goes back into reset the cycle after START
        check("reload_pre_rstn", int'(cpu_reset_n), 1);
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("reload_rstn", int'(cpu_reset_n), 0);
        check("reload_busy", int'(busy), 1);
        check("reload_done", int'(done), 0);
        send_byte(8'h01, 0);
        send_byte(8'h80, 0);
        send_byte(8'h01, 0);
        send_byte(8'h80, 0);
        repeat (3) @(negedge clk);
        check("reload_done_after", int'(done), 1);

        // Timeout: error must rise exactly TIMEOUT idle cycles after the last byte
        nobs = obs.size();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        c0    = acc[acc.size() - 1];
        first = -1;
        for (int k = 0; k < TIMEOUT + 100 && first < 0; k++) begin
            @(negedge clk);
            if (error) first = cyc;
        end
        check("timeout_cycle", first, c0 + TIMEOUT);
        check("timeout_busy", int'(busy), 0);
        check("timeout_no_load", obs.size() - nobs, 0);

        // Reset asserted while waiting for a DATA byte
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h80, 0);
        check("mid_busy_before", int'(busy), 1);
        nobs = obs.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        #2;
        reset = 1'b0;
        #1;
        check("mid_busy", int'(busy), 0);
        check("mid_cpu_reset_n", int'(cpu_reset_n), 0);
        check("mid_load", int'(load), 0);
        check("mid_cpu_input", int'(cpu_input), 0);
        check("mid_load_address", int'(load_address), 0);
        check("mid_in_ready", int'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_no_load", obs.size() - nobs, 0);
        check("mid_idle_busy", int'(busy), 0);
        check("mid_idle_ready", int'(in_ready), 1);

        // Randomized streams with gaps against the parser model
        for (int r = 0; r < 8; r++) begin
            bq_t s;
            int  st, gap;
            @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            s.delete();
            for (int f = 0; f < 6; f++) begin
                int         kind, cnt;
                logic [7:0] sum, c, d;
                kind = $urandom_range(0, 9);
                if (kind == 9) begin
                    repeat ($urandom_range(1, 3)) begin
                        c = 8'($urandom_range(0, 255));
                        if (c == 8'hA5) c = 8'h00;
                        s.push_back(c);
                    end
                end
                if (kind == 8) begin
                    s.push_back(8'hA5);
                    s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
                end else begin
                    cnt = (f == r % 6) ? 32 : $urandom_range(1, 8);
                    s.push_back(8'hA5);
                    s.push_back(8'(cnt));
                    sum = 8'(cnt);
                    for (int k = 0; k < cnt; k++) begin
                        c = 8'($urandom_range(0, 255));
                        d = 8'($urandom_range(0, 255));
                        s.push_back(c);
                        s.push_back(d);
                        sum = sum ^ c ^ d;
                    end
                    if (kind == 6 || kind == 7) sum = sum ^ 8'($urandom_range(1, 255));
                    s.push_back(sum);
                end
            end
            run_model(s, st);
            base_obs = obs.size();
            base_acc = acc.size();
            foreach (s[i]) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
                send_byte(s[i], gap);
            end
            repeat (3) @(negedge clk);
            check("rnd_load_count", obs.size() - base_obs, exp_q.size());
            for (int i = 0; i < exp_q.size() && base_obs + i < obs.size(); i++) begin
                check("rnd_addr", obs[base_obs + i].addr, exp_q[i].addr);
                check("rnd_instr", obs[base_obs + i].instr, exp_q[i].instr);
                check("rnd_data", obs[base_obs + i].data, exp_q[i].data);
                if (base_acc + exp_q[i].idx < acc.size())
                    check("rnd_latency", obs[base_obs + i].cyc, acc[base_acc + exp_q[i].idx]);
            end
            check("rnd_error", int'(error), (st == ST_ERR) ? 1 : 0);
            check("rnd_done", int'(done), (st == ST_DONE) ? 1 : 0);
            check("rnd_cpu_reset_n", int'(cpu_reset_n), (st == ST_DONE) ? 1 : 0);
            check("rnd_busy", int'(busy), (st == ST_BUSY) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
